ps2_rx_fifo: RTL
================

Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 device-to-host receiver with a configurable-depth first-word-fall-through FIFO.
- Adds the following to the receive path:
  - start-bit resynchronisation;
  - an inter-bit watchdog timeout;
  - error reporting;
  - an occupancy count;
  - a lossless full-FIFO policy that drops new data rather than corrupting stored data.
- Sits between the board PS/2 pins and the keyboard MMIO/CPU-side consumer on the system clock domain.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TIMEOUT, 20000, clk cycles with no ps2_clk falling edge before a partial frame is abandoned (200 us at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- rd_en  in  1  pop request; honoured only while valid=1.
- clr_flags  in  1  clears overflow; synchronous, one cycle.
- data  out  DW  head FIFO entry; DW=8, or 10 with PS2_PREFIX_TAG_EN.
- valid  out  1  FIFO non-empty.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a valid frame was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse per rejected or abandoned frame.

Behaviour:
- Reset (async, rst=1):
  - bit counter, pointers, level, overflow, frame_err, prefix flags all 0; valid=0.
  - Synchroniser flops reset to 1 (idle bus).
  - FIFO memory is not reset.
- Input synchronisation:
  - ps2_clk and ps2_data each pass through 2 synchroniser flops.
  - A third flop on the clock path detects falling edges: fall = prev & ~cur.
  - On fall, the synchronised ps2_data is sampled.
- Frame FSM (bit counter 0..10):
  - Bit 0 (start): if the sample is 1, discard it and stay at 0; no error is flagged (resync on a noise edge).
  - Bits 1..8: data, LSB first.
  - Bit 9: parity.
  - Bit 10: stop.
  - On the bit-10 sample, the frame is good when stop=1 and the XOR of data[7:0] and parity is 1 (odd parity).
  - Good frame: push into the FIFO.
  - Bad frame: frame_err=1 for one cycle; nothing pushed.
  - The counter returns to 0 in either case.
- Watchdog:
  - Cycle counter reloads on every fall; runs only while bit counter != 0.
  - On reaching TIMEOUT-1 with no fall: bit counter is set to 0 and frame_err pulses.
- FIFO:
  - Pointers are $clog2(DEPTH)+1 bits with natural wrap; full/empty are decided by the MSB compare.
  - data = mem[r_ptr] combinationally (first-word fall-through).
  - valid = (level != 0).
  - Push latency: the pushed byte appears on data with valid=1 on the cycle after the bit-10 fall cycle.
  - rd_en with valid=1 advances r_ptr on that clock edge. rd_en with valid=0 is ignored; no underflow.
  - Push while full with no pop: byte dropped, overflow set to 1, stored entries unchanged.
  - Push and pop on the same cycle while full: both happen, level stays DEPTH, overflow unchanged.
  - Push and pop on the same cycle while non-full: level unchanged.
- overflow:
  - Cleared only by rst or clr_flags.
  - If clr_flags and a new drop occur on the same cycle, the drop wins and overflow=1.

Optional Feature:
- Macro: PS2_PREFIX_TAG_EN.
- Defined:
  - DW=10, data = {brk, ext, code[7:0]}.
  - Good frame 0xE0: not pushed; sets pending ext.
  - Good frame 0xF0: not pushed; sets pending brk.
  - Any other good code: pushed with the pending flags attached, then both flags clear.
  - frame_err or timeout clears the pending flags.
  - Overflow on a tagged push also clears the flags.
  - Example: E0 F0 75 pushes a single entry, 0x375.
- Undefined:
  - DW=8; every good byte, including E0/F0, is pushed raw.

Test Plan:
- Reset mid-frame: 5 bits sent, then rst pulsed -> level=0, valid=0, overflow=0. A following clean 0x1C frame gives data=0x1C, level=1.
- Single good frame 0x1C (parity 0) -> frame_err stays 0; valid rises one cycle after the stop edge; data=0x1C; after rd_en, valid=0.
- Bad parity: 0x1C sent with parity 1 -> frame_err one pulse, level=0. Bad stop bit (0) -> same.
- Timeout: 4 bits sent, then ps2_clk held high for TIMEOUT cycles -> frame_err pulse. Next frame 0x32 is received correctly.
- Overflow at DEPTH=8:
  - 9 good frames 0x01..0x09 with no reads -> level=8, overflow=1, reads return 0x01..0x08.
  - Full FIFO with rd_en asserted on the push cycle -> no overflow, level=8.
  - clr_flags -> overflow=0.
- With PS2_PREFIX_TAG_EN:
  - E0 F0 75 then 1C -> entries 0x375, 0x01C.
  - E0 followed by a bad-parity frame, then 1C -> 0x01C with ext cleared.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a first-word-fall-through FIFO, watchdog and error flags.
// Build option: define PS2_PREFIX_TAG_EN to fold E0/F0 prefixes into {brk, ext, code} entries.
module ps2_rx_fifo #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 20000,
`ifdef PS2_PREFIX_TAG_EN
   localparam int DW     = 10,
`else
   localparam int DW     = 8,
`endif
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ps2_clk,
   input  logic          ps2_data,
   input  logic          rd_en,
   input  logic          clr_flags,
   output logic [DW-1:0] data,
   output logic          valid,
   output logic [AW:0]   level,
   output logic          overflow,
   output logic          frame_err
);

   localparam int WW = $clog2(TIMEOUT);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   logic          clk_s1, clk_s2, clk_s3;
   logic          dat_s1, dat_s2;
   logic          fall;
   state_t        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [WW-1:0] wd_q;
   logic          timeout;
   logic          frame_good, frame_bad;
   logic          err_pulse;
   logic          push_req;
   logic [DW-1:0] push_word;
   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   w_ptr, r_ptr;
   logic          full, pop, do_push, drop;

   // Synchronisers idle high so reset never fabricates a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_s3 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   assign fall    = clk_s3 & ~clk_s2;
   assign timeout = (state_q != ST_START) && !fall && (wd_q == WD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q <= '0;
      end else if (fall || state_q == ST_START) begin
         wd_q <= '0;
      end else if (!timeout) begin
         wd_q <= wd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_START;
         idx_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         frame_err <= err_pulse;
      end
   end

   // A high start sample is treated as a noise edge: stay put, no error.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      par_d      = par_q;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      if (timeout) begin
         state_d = ST_START;
      end else if (fall) begin
         case (state_q)
            ST_START: begin
               if (!dat_s2) begin
                  state_d = ST_DATA;
                  idx_d   = '0;
               end
            end
            ST_DATA: begin
               shift_d = {dat_s2, shift_q[7:1]};
               idx_d   = idx_q + 1'b1;
               if (idx_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_d   = dat_s2;
               state_d = ST_STOP;
            end
            default: begin
               state_d = ST_START;
               if (dat_s2 && ((^shift_q) ^ par_q)) frame_good = 1'b1;
               else                                 frame_bad  = 1'b1;
            end
         endcase
      end
   end

   assign err_pulse = timeout | frame_bad;

`ifdef PS2_PREFIX_TAG_EN
   logic ext_q, brk_q;
   logic is_prefix;

   assign is_prefix = (shift_q == 8'hE0) || (shift_q == 8'hF0);
   assign push_req  = frame_good && !is_prefix;
   assign push_word = {brk_q, ext_q, shift_q};

   // Flags clear on any push attempt, accepted or dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (err_pulse) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (frame_good) begin
         if (shift_q == 8'hE0) begin
            ext_q <= 1'b1;
         end else if (shift_q == 8'hF0) begin
            brk_q <= 1'b1;
         end else begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end
      end
   end
`else
   assign push_req  = frame_good;
   assign push_word = shift_q;
`endif

   // Consumer handshake: an entry is taken on a clock edge where valid=1 and rd_en=1;
   // rd_en while valid=0 has no effect. data is stable while valid=1 and no pop occurs.
   assign full    = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
   assign valid   = (w_ptr != r_ptr);
   assign level   = w_ptr - r_ptr;
   assign pop     = rd_en & valid;
   assign do_push = push_req & (~full | pop);
   assign drop    = push_req & full & ~pop;
   assign data    = mem[r_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) mem[w_ptr[AW-1:0]] <= push_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_ptr    <= '0;
         r_ptr    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) w_ptr <= w_ptr + 1'b1;
         if (pop)     r_ptr <= r_ptr + 1'b1;
         if (drop)           overflow <= 1'b1;
         else if (clr_flags) overflow <= 1'b0;
      end
   end

endmodule
